// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen: counters, syncs, strobes and tile coordinates.
// The generator drives the master side; the bit generator / tile renderer sees the slave side.
interface vga_timing_gen_if #(
   parameter int CNT_W     = 10,
   parameter int TILE_LOG2 = 4,
   parameter int ADDR_W    = 11
);
   logic [CNT_W-1:0]           hCount;
   logic [CNT_W-1:0]           vCount;
   logic                       hSync;
   logic                       vSync;
   logic                       bright;
   logic                       pixTick;
   logic                       lineStart;
   logic                       frameStart;
   logic [CNT_W-TILE_LOG2-1:0] tileCol;
   logic [CNT_W-TILE_LOG2-1:0] tileRow;
   logic [TILE_LOG2-1:0]       tilePixX;
   logic [TILE_LOG2-1:0]       tilePixY;
   logic [ADDR_W-1:0]          tileAddr;

   modport master (
      output hCount, vCount, hSync, vSync, bright, pixTick, lineStart, frameStart,
             tileCol, tileRow, tilePixX, tilePixY, tileAddr
   );
   modport slave (
      input  hCount, vCount, hSync, vSync, bright, pixTick, lineStart, frameStart,
             tileCol, tileRow, tilePixX, tilePixY, tileAddr
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-rate divider, registered
// sync/bright decode and an incrementally computed linear tile address.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_ACTIVE  = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int SYNC_POL  = 0,
   parameter int TILE_LOG2 = 4,
   parameter int CNT_W     = 10,
   parameter int ADDR_W    = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   vga_timing_gen_if.master vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int COL_W   = CNT_W - TILE_LOG2;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0]  H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0]  V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0]  HS_START = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0]  HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0]  VS_START = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0]  VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [ADDR_W-1:0] TILES_X  = ADDR_W'(H_ACTIVE >> TILE_LOG2);
   localparam logic              SYNC_ON  = (SYNC_POL != 0);

   logic [DIV_W-1:0]  divCnt;
   logic [CNT_W-1:0]  hCount, vCount, hNext, vNext;
   logic [COL_W-1:0]  colBase, colNext;
   logic [ADDR_W-1:0] rowBase, rowNext, tileAddrQ, addrNext;
   logic              hSyncQ, vSyncQ, brightQ;
   logic              hSyncNext, vSyncNext, brightNext;
   logic              pixTick, lineStart, hWrap, frameWrap;

   assign pixTick   = enable & ~reset & (divCnt == DIV_LAST);
   assign hWrap     = (hCount == H_LAST);
   assign frameWrap = hWrap & (vCount == V_LAST);
   assign lineStart = pixTick & (hCount == '0);

   // Everything registered is loaded from the next-state position, so the
   // decoded outputs never lag the counters they describe.
   always_comb begin
      hNext   = hCount;
      vNext   = vCount;
      colNext = colBase;
      rowNext = rowBase;
      if (pixTick) begin
         if (hWrap) begin
            hNext   = '0;
            colNext = '0;
            if (frameWrap) begin
               vNext   = '0;
               rowNext = '0;
            end else begin
               vNext = vCount + CNT_W'(1);
               if (vNext[TILE_LOG2-1:0] == '0) rowNext = rowBase + TILES_X;
            end
         end else begin
            hNext = hCount + CNT_W'(1);
            if (hNext[TILE_LOG2-1:0] == '0) colNext = colBase + COL_W'(1);
         end
      end
      brightNext = (hNext < H_ACT) && (vNext < V_ACT);
      hSyncNext  = (hNext >= HS_START && hNext < HS_END) ? SYNC_ON : ~SYNC_ON;
      vSyncNext  = (vNext >= VS_START && vNext < VS_END) ? SYNC_ON : ~SYNC_ON;
      addrNext   = brightNext ? rowNext + ADDR_W'(colNext) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         divCnt    <= '0;
         hCount    <= '0;
         vCount    <= '0;
         colBase   <= '0;
         rowBase   <= '0;
         hSyncQ    <= ~SYNC_ON;
         vSyncQ    <= ~SYNC_ON;
         // Holds the decode of (0,0) so the first post-reset cycle is visible.
         brightQ   <= 1'b1;
         tileAddrQ <= '0;
      end else begin
         if (enable) divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + DIV_W'(1);
         hCount    <= hNext;
         vCount    <= vNext;
         colBase   <= colNext;
         rowBase   <= rowNext;
         hSyncQ    <= hSyncNext;
         vSyncQ    <= vSyncNext;
         brightQ   <= brightNext;
         tileAddrQ <= addrNext;
      end
   end

   // Decoded outputs read inactive for as long as reset is held.
   assign vga.hCount     = hCount;
   assign vga.vCount     = vCount;
   assign vga.hSync      = reset ? ~SYNC_ON : hSyncQ;
   assign vga.vSync      = reset ? ~SYNC_ON : vSyncQ;
   assign vga.bright     = brightQ & ~reset;
   assign vga.tileAddr   = reset ? '0 : tileAddrQ;
   assign vga.pixTick    = pixTick;
   assign vga.lineStart  = lineStart;
   assign vga.frameStart = lineStart & (vCount == '0);
   assign vga.tileCol    = hCount[CNT_W-1:TILE_LOG2];
   assign vga.tileRow    = vCount[CNT_W-1:TILE_LOG2];
   assign vga.tilePixX   = hCount[TILE_LOG2-1:0];
   assign vga.tilePixY   = vCount[TILE_LOG2-1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default config (reset, first pixels, line timing), a scaled 80x56
// config for whole-frame, enable and reset behaviour, and the tiny 12x7 config.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rstD = 1'b1, rstM = 1'b1, rstS = 1'b1;
   logic enD = 1'b1, enM = 1'b1, enS = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_gen_if #(.CNT_W(10), .TILE_LOG2(4), .ADDR_W(11)) dIf ();
   vga_timing_gen_if #(.CNT_W(7),  .TILE_LOG2(4), .ADDR_W(8))  mIf ();
   vga_timing_gen_if #(.CNT_W(4),  .TILE_LOG2(1), .ADDR_W(4))  sIf ();

   vga_timing_gen dutD (.clk(clk), .reset(rstD), .enable(enD), .vga(dIf));

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_ACTIVE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(4), .SYNC_POL(0),
      .TILE_LOG2(4), .CNT_W(7), .ADDR_W(8)
   ) dutM (.clk(clk), .reset(rstM), .enable(enM), .vga(mIf));

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1),
      .TILE_LOG2(1), .CNT_W(4), .ADDR_W(4)
   ) dutS (.clk(clk), .reset(rstS), .enable(enS), .vga(sIf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit atPos(input int sel, input int h, input int v);
      if (sel == 0) return int'(dIf.hCount) == h && int'(dIf.vCount) == v;
      return int'(mIf.hCount) == h && int'(mIf.vCount) == v;
   endfunction

   function automatic bit evHit(input int sel);
      case (sel)
         0:       return mIf.frameStart;
         1:       return mIf.lineStart;
         2:       return sIf.frameStart;
         default: return dIf.lineStart;
      endcase
   endfunction

   task automatic waitPos(input int sel, input int h, input int v, input string tag);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 20000) begin
         @(negedge clk); n++;
         hit = atPos(sel, h, v);
      end
      chk({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic waitEv(input int sel, input string tag);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 20000) begin
         @(negedge clk); n++;
         hit = evHit(sel);
      end
      chk({tag, "_seen"}, 32'(hit), 32'd1);
   endtask

   initial begin
      int t0, n, hHi, vHi, err, ls, bt, pH, pV;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_hCount",  dIf.hCount, 0);
      chk("rst_vCount",  dIf.vCount, 0);
      chk("rst_hSync",   dIf.hSync, 1);
      chk("rst_vSync",   dIf.vSync, 1);
      chk("rst_bright",  dIf.bright, 0);
      chk("rst_addr",    dIf.tileAddr, 0);
      chk("rst_tick",    dIf.pixTick, 0);
      chk("rst_frame",   dIf.frameStart, 0);
      chk("rst_sHsync",  sIf.hSync, 0);
      chk("rst_sTick",   sIf.pixTick, 0);

      // First cycles after release
      @(posedge clk); #1;
      rstD = 1'b0; rstM = 1'b0; rstS = 1'b0;
      @(negedge clk);
      chk("c0_bright",   dIf.bright, 1);
      chk("c0_hSync",    dIf.hSync, 1);
      chk("c0_vSync",    dIf.vSync, 1);
      chk("c0_addr",     dIf.tileAddr, 0);
      chk("c0_tick",     dIf.pixTick, 0);
      chk("c0_sTick",    sIf.pixTick, 1);
      chk("c0_sFrame",   sIf.frameStart, 1);
      chk("c0_mTick",    mIf.pixTick, 0);
      @(negedge clk);
      chk("c1_tick",     dIf.pixTick, 1);
      chk("c1_frame",    dIf.frameStart, 1);
      chk("c1_hCount",   dIf.hCount, 0);
      chk("c1_sHCount",  sIf.hCount, 1);
      chk("c1_sFrame",   sIf.frameStart, 0);
      chk("c1_mFrame",   mIf.frameStart, 1);
      @(negedge clk);
      chk("c2_hCount",   dIf.hCount, 1);
      chk("c2_tick",     dIf.pixTick, 0);

      // Default config: tile outputs and horizontal timing on line 0
      waitPos(0, 17, 0, "d17");
      chk("d17_addr",    dIf.tileAddr, 1);
      chk("d17_col",     dIf.tileCol, 1);
      chk("d17_row",     dIf.tileRow, 0);
      chk("d17_pixX",    dIf.tilePixX, 1);
      chk("d17_pixY",    dIf.tilePixY, 0);
      waitPos(0, 640, 0, "d640");
      chk("d640_bright", dIf.bright, 0);
      chk("d640_addr",   dIf.tileAddr, 0);
      chk("d640_hSync",  dIf.hSync, 1);
      waitPos(0, 656, 0, "d656");
      n = 0;
      while (dIf.hSync == 1'b0 && n < 1000) begin @(negedge clk); n++; end
      chk("d_hSyncLow",  n, 192);
      waitEv(3, "dLine0");
      t0 = cyc;
      waitEv(3, "dLine1");
      chk("d_linePer",   cyc - t0, 1600);

      // Tiny config: one full frame
      waitEv(2, "sFrame0");
      t0 = cyc; n = 0; hHi = 0; vHi = 0; err = 0; pH = 0; pV = 0;
      do begin
         pH = int'(sIf.hCount); pV = int'(sIf.vCount);
         @(negedge clk); n++;
         if (sIf.hSync) hHi++;
         if (sIf.vSync) vHi++;
         if (sIf.hSync !== (sIf.hCount >= 9 && sIf.hCount <= 10)) err++;
      end while (!sIf.frameStart && n < 200);
      chk("s_period",    cyc - t0, 84);
      chk("s_hSyncHi",   hHi, 14);
      chk("s_vSyncHi",   vHi, 12);
      chk("s_hSyncPos",  err, 0);
      chk("s_prevH",     pH, 11);
      chk("s_prevV",     pV, 6);
      chk("s_wrapH",     sIf.hCount, 0);
      chk("s_wrapV",     sIf.vCount, 0);

      // Scaled config: tiles and syncs
      waitPos(1, 17, 33, "m17");
      chk("m17_addr",    mIf.tileAddr, 9);
      chk("m17_col",     mIf.tileCol, 1);
      chk("m17_row",     mIf.tileRow, 2);
      chk("m17_pixX",    mIf.tilePixX, 1);
      chk("m17_pixY",    mIf.tilePixY, 1);
      chk("m17_bright",  mIf.bright, 1);
      waitPos(1, 64, 33, "m64");
      chk("m64_bright",  mIf.bright, 0);
      chk("m64_addr",    mIf.tileAddr, 0);
      chk("m64_hSync",   mIf.hSync, 1);
      waitPos(1, 68, 33, "m68");
      n = 0;
      while (mIf.hSync == 1'b0 && n < 1000) begin @(negedge clk); n++; end
      chk("m_hSyncLow",  n, 16);
      waitPos(1, 63, 47, "mLast");
      chk("mLast_addr",  mIf.tileAddr, 11);
      chk("mLast_brt",   mIf.bright, 1);
      waitPos(1, 79, 49, "m79");
      chk("m79_vSync",   mIf.vSync, 1);
      waitPos(1, 0, 50, "mV50");
      n = 0;
      while (mIf.vSync == 1'b0 && n < 1000) begin @(negedge clk); n++; end
      chk("m_vSyncLow",  n, 320);

      // Scaled config: whole-frame statistics
      waitEv(0, "mFrame0");
      t0 = cyc; n = 0; ls = 0; bt = 0;
      do begin
         @(negedge clk); n++;
         if (mIf.lineStart) ls++;
         if (mIf.bright && mIf.pixTick) bt++;
      end while (!mIf.frameStart && n < 20000);
      chk("m_period",    cyc - t0, 8960);
      chk("m_lines",     ls, 56);
      chk("m_brightTk",  bt, 3072);
      t0 = cyc;
      waitEv(1, "mLine");
      chk("m_linePer",   cyc - t0, 160);

      // Enable dropped for 37 cycles mid-line
      waitEv(0, "mFrame1");
      t0 = cyc;
      waitPos(1, 30, 10, "mEn");
      @(posedge clk); #1 enM = 1'b0;
      err = 0;
      for (int i = 0; i < 37; i++) begin
         @(negedge clk);
         if (mIf.pixTick || mIf.lineStart || mIf.frameStart || mIf.hCount != 7'd30 ||
             mIf.vCount != 7'd10 || !mIf.bright || mIf.tileAddr != 8'd1 || !mIf.hSync) err++;
      end
      chk("en_hold",     err, 0);
      @(posedge clk); #1 enM = 1'b1;
      @(negedge clk);
      chk("en_tick",     mIf.pixTick, 1);
      chk("en_hCount",   mIf.hCount, 30);
      @(negedge clk);
      chk("en_next",     mIf.hCount, 31);
      waitEv(0, "mFrame2");
      chk("en_period",   cyc - t0, 8960 + 37);

      // One-cycle reset while hSync is active
      waitPos(1, 70, 40, "mRst");
      chk("mRst_hSync",  mIf.hSync, 0);
      @(posedge clk); #1 rstM = 1'b1;
      @(posedge clk); #1 rstM = 1'b0;
      @(negedge clk);
      chk("rs_hCount",   mIf.hCount, 0);
      chk("rs_vCount",   mIf.vCount, 0);
      chk("rs_hSync",    mIf.hSync, 1);
      chk("rs_vSync",    mIf.vSync, 1);
      chk("rs_bright",   mIf.bright, 1);
      chk("rs_addr",     mIf.tileAddr, 0);
      chk("rs_frame0",   mIf.frameStart, 0);
      @(negedge clk);
      chk("rs_frame1",   mIf.frameStart, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
